// File: rtl/counter_stim_gen_pkg.sv
// Shared definitions for the counter stimulus generator: counter mode codes,
// the run state encoding (which doubles as the phase code), and state helpers.
package counter_stim_gen_pkg;

    // Counter mode codes driven on modo
    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DN   = 2'b01;
    localparam logic [1:0] MODE_DN3  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Run states; the low three bits are the phase code seen outside.
    // DONE shares phase code 7 with HOLD and is told apart by the done pulse.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_RST  = 4'd1,
        ST_LOAD = 4'd2,
        ST_UP   = 4'd3,
        ST_DN   = 4'd4,
        ST_DN3  = 4'd5,
        ST_RAND = 4'd6,
        ST_HOLD = 4'd7,
        ST_DONE = 4'd8
    } state_e;

    // Fixed order of the directed run
    function automatic state_e state_succ(input state_e s);
        case (s)
            ST_RST:  return ST_LOAD;
            ST_LOAD: return ST_UP;
            ST_UP:   return ST_DN;
            ST_DN:   return ST_DN3;
            ST_DN3:  return ST_RAND;
            ST_RAND: return ST_HOLD;
            ST_HOLD: return ST_DONE;
            default: return ST_IDLE;
        endcase
    endfunction

    // Phase code published on the phase output
    function automatic logic [2:0] phase_of(input state_e s);
        logic [3:0] code;
        code = s;
        return (s == ST_DONE) ? 3'd7 : code[2:0];
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting left with the
// feedback bit entering bit 0. Reset and load both restore the seed.
module lfsr8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       shift,
    output logic [7:0] q
);

    logic feedback;

    // Feedback taps for bits 8,6,5,4 of the polynomial
    always_comb feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

    // Seed on reset or load, otherwise advance only when asked
    always_ff @(posedge clk) begin
        if (reset || load) begin
            q <= seed;
        end else if (shift) begin
            q <= {q[6:0], feedback};
        end
    end

endmodule

// File: rtl/counter_stim_gen.sv
// Directed stimulus generator for the 4-bit up/down/load counter. Walks
// reset, load, up, down, down-by-3, pseudo-random and hold phases, then
// pulses done. Every output is a register so the counter and scoreboard see
// clean, edge-aligned stimulus.
//   RESET_LEN : 1..15 cycles of rst_o
//   PHASE_LEN : 1..255 cycles per UP/DN/DN3/RAND phase
//   LFSR_SEED : nonzero
module counter_stim_gen
    import counter_stim_gen_pkg::*;
#(
    parameter int         RESET_LEN = 2,
    parameter logic [3:0] LOAD_VAL  = 4'hA,
    parameter int         PHASE_LEN = 20,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] D,
    output logic [1:0] modo,
    output logic       enable,
    output logic       rst_o,
    output logic [2:0] phase,
    output logic       busy,
    output logic       done
);

    state_e     state, next_state;
    logic [7:0] cnt, next_cnt;

    logic [3:0] d_nxt;
    logic [1:0] modo_nxt;
    logic       enable_nxt, rst_nxt, done_nxt;

    logic [7:0] lfsr_q;
    logic       lfsr_load, lfsr_shift;

    // Phase counter reload value (length - 1) for a state being entered
    function automatic logic [7:0] len_m1(input state_e s);
        case (s)
            ST_RST:                        return 8'(RESET_LEN - 1);
            ST_UP, ST_DN, ST_DN3, ST_RAND: return 8'(PHASE_LEN - 1);
            ST_HOLD:                       return 8'd1;
            default:                       return 8'd0;
        endcase
    endfunction

    // The LFSR restarts from the seed throughout RST and steps once for each
    // RAND cycle, in step with the registered RAND outputs that sample it.
    always_comb begin
        lfsr_load  = (state == ST_RST);
        lfsr_shift = (next_state == ST_RAND);
    end

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .seed  (LFSR_SEED),
        .shift (lfsr_shift),
        .q     (lfsr_q)
    );

    // Next state and phase counter: hold until the counter reaches zero, then
    // advance and reload; stop aborts any active run straight to IDLE.
    // NOTE: combinational blocks assign every output a default first and use
    // blocking '='; that keeps them latch-free. Registers use '<=' only.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        if (state == ST_IDLE) begin
            if (start && !stop) begin
                next_state = ST_RST;
                next_cnt   = len_m1(ST_RST);
            end
        end else if (stop) begin
            next_state = ST_IDLE;
            next_cnt   = 8'd0;
        end else if (cnt == 8'd0) begin
            next_state = state_succ(state);
            next_cnt   = len_m1(state_succ(state));
        end else begin
            next_cnt = cnt - 8'd1;
        end
    end

    // Output values for the state about to be entered, so they register
    // together with the state itself
    always_comb begin
        d_nxt      = 4'd0;
        modo_nxt   = MODE_UP;
        enable_nxt = 1'b0;
        rst_nxt    = 1'b0;
        done_nxt   = 1'b0;
        case (next_state)
            ST_RST: begin
                enable_nxt = 1'b1;
                rst_nxt    = 1'b1;
            end
            ST_LOAD: begin
                enable_nxt = 1'b1;
                modo_nxt   = MODE_LOAD;
                d_nxt      = LOAD_VAL;
            end
            ST_UP: begin
                enable_nxt = 1'b1;
                modo_nxt   = MODE_UP;
            end
            ST_DN: begin
                enable_nxt = 1'b1;
                modo_nxt   = MODE_DN;
            end
            ST_DN3: begin
                enable_nxt = 1'b1;
                modo_nxt   = MODE_DN3;
            end
            ST_RAND: begin
                modo_nxt   = lfsr_q[1:0];
                d_nxt      = lfsr_q[5:2];
                enable_nxt = ~(lfsr_q[7] & lfsr_q[6]);
            end
            ST_DONE: done_nxt = 1'b1;
            default: ;
        endcase
    end

    // State, counter and all outputs registered; reset overrides start/stop
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= 8'd0;
            D      <= 4'd0;
            modo   <= MODE_UP;
            enable <= 1'b0;
            rst_o  <= 1'b0;
            phase  <= 3'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            D      <= d_nxt;
            modo   <= modo_nxt;
            enable <= enable_nxt;
            rst_o  <= rst_nxt;
            phase  <= phase_of(next_state);
            busy   <= (next_state != ST_IDLE);
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_counter_stim_gen.sv
// Directed bench for counter_stim_gen with RESET_LEN=2, PHASE_LEN=4,
// LOAD_VAL=A. A behavioural 4-bit counter is driven from the generator's
// outputs so the resulting count sequence is checked as well.
module tb_counter_stim_gen;

    logic       clk = 1'b0;
    logic       reset, start, stop;
    logic [3:0] D;
    logic [1:0] modo;
    logic       enable, rst_o;
    logic [2:0] phase;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    // {D, modo, enable, rst_o, phase, busy, done}
    typedef logic [12:0] vec_t;
    vec_t obs;
    assign obs = {D, modo, enable, rst_o, phase, busy, done};

    always #5 clk = ~clk;

    counter_stim_gen #(
        .RESET_LEN (2),
        .LOAD_VAL  (4'hA),
        .PHASE_LEN (4),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .D      (D),
        .modo   (modo),
        .enable (enable),
        .rst_o  (rst_o),
        .phase  (phase),
        .busy   (busy),
        .done   (done)
    );

    // Reference counter fed by the generator outputs
    logic [3:0] q_m   = 4'd0;
    logic       rco_m = 1'b0;
    always @(posedge clk) begin
        if (enable) begin
            if (rst_o) begin
                q_m   <= 4'd0;
                rco_m <= 1'b0;
            end else begin
                case (modo)
                    2'b00: begin q_m <= q_m + 4'd1; rco_m <= (q_m == 4'hF); end
                    2'b01: begin q_m <= q_m - 4'd1; rco_m <= (q_m == 4'h0); end
                    2'b10: begin q_m <= q_m - 4'd3; rco_m <= (q_m < 4'd3);  end
                    default: begin q_m <= D; rco_m <= 1'b0; end
                endcase
            end
        end else begin
            rco_m <= 1'b0;
        end
    end

    // RAND cycles from seed A5: {D, modo, enable}
    // A5 -> 4A -> 95 -> 2A
    logic [6:0] rand_tab [4];
    initial begin
        rand_tab[0] = {4'h9, 2'b01, 1'b1};
        rand_tab[1] = {4'h2, 2'b10, 1'b1};
        rand_tab[2] = {4'h5, 2'b01, 1'b1};
        rand_tab[3] = {4'hA, 2'b10, 1'b1};
    end

    function automatic vec_t mk(input logic [3:0] d, input logic [1:0] m, input logic en,
                                input logic r, input logic [2:0] ph, input logic b,
                                input logic dn);
        return {d, m, en, r, ph, b, dn};
    endfunction

    // Expected outputs n edges after start is first sampled (n=1 is first RST cycle)
    function automatic vec_t sched(input int n);
        logic [6:0] r;
        if (n >= 1 && n <= 2)        return mk(4'h0, 2'b00, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        else if (n == 3)             return mk(4'hA, 2'b11, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
        else if (n >= 4 && n <= 7)   return mk(4'h0, 2'b00, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
        else if (n >= 8 && n <= 11)  return mk(4'h0, 2'b01, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
        else if (n >= 12 && n <= 15) return mk(4'h0, 2'b10, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
        else if (n >= 16 && n <= 19) begin
            r = rand_tab[n-16];
            return mk(r[6:3], r[2:1], r[0], 1'b0, 3'd6, 1'b1, 1'b0);
        end
        else if (n == 20 || n == 21) return mk(4'h0, 2'b00, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0);
        else if (n == 22)            return mk(4'h0, 2'b00, 1'b0, 1'b0, 3'd7, 1'b1, 1'b1);
        return 13'd0;
    endfunction

    // Expected counter value after edge n (0 = not checked at that point)
    function automatic int q_exp(input int n);
        case (n)
            4:  return 'hA;
            8:  return 'hE;
            12: return 'hA;
            13: return 7;
            14: return 4;
            15: return 1;
            16: return 'hE;
            default: return -1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run, every cycle compared; optionally pokes start mid-run
    task automatic run_and_check(input string name, input bit poke_start);
        start = 1'b1;
        for (int n = 1; n <= 23; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (poke_start && n == 5) start = 1'b1;
            if (poke_start && n == 9) start = 1'b0;
            checks++;
            if (obs !== sched(n)) begin
                errors++;
                $display("FAIL %s outputs n=%0d: got %h want %h", name, n, obs, sched(n));
            end
            if (q_exp(n) >= 0) begin
                checks++;
                if (q_m !== 4'(q_exp(n))) begin
                    errors++;
                    $display("FAIL %s counter n=%0d: got %h want %h", name, n, q_m, 4'(q_exp(n)));
                end
            end
            if (n == 15 || n == 16) begin
                checks++;
                if (rco_m !== (n == 16)) begin
                    errors++;
                    $display("FAIL %s rco n=%0d: got %b want %b", name, n, rco_m, (n == 16));
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) start = 1'b1;
            tick();
            checks++;
            if (obs !== 13'd0) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h want %h", i, obs, 13'd0);
            end
        end
        start = 1'b0;
        reset = 1'b0;
        tick();
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset release: got %h want %h", obs, 13'd0);
        end
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1;
        stop  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== 13'd0) begin
                errors++;
                $display("FAIL start_stop_idle cycle %0d: got %h want %h", i, obs, 13'd0);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_full_run();
        run_and_check("full_run", 1'b0);
    endtask

    task automatic test_back_to_back();
        run_and_check("b2b_first", 1'b0);
        run_and_check("b2b_second_poked", 1'b1);
    endtask

    task automatic test_stop();
        start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            if (n == 1) start = 1'b0;
        end
        checks++;
        if (obs !== sched(5)) begin
            errors++;
            $display("FAIL stop pre-abort: got %h want %h", obs, sched(5));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== 13'd0) begin
                errors++;
                $display("FAIL stop idle cycle %0d: got %h want %h", i, obs, 13'd0);
            end
            tick();
        end
        run_and_check("after_stop", 1'b0);
    endtask

    task automatic test_reset_mid_rand();
        start = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            tick();
            if (n == 1) start = 1'b0;
        end
        checks++;
        if (obs !== sched(17)) begin
            errors++;
            $display("FAIL mid_rand pre-reset: got %h want %h", obs, sched(17));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs !== 13'd0) begin
                errors++;
                $display("FAIL mid_rand idle cycle %0d: got %h want %h", i, obs, 13'd0);
            end
            tick();
        end
        run_and_check("after_mid_reset", 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        test_reset();
        test_start_stop_idle();
        test_full_run();
        test_back_to_back();
        test_stop();
        test_reset_mid_rand();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
